// File: rtl/usb_rx_pkt_pkg.sv
// usb_rx_pkt_pkg: shared PID/FSM types, CRC constants and the CRC5 byte update
package usb_rx_pkt_pkg;
  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE,
    PID_PRE   = 4'hC
  } pid_t;
  typedef enum logic [2:0] {S_IDLE, S_PID, S_TOK1, S_TOK2, S_TEND, S_HSK, S_DATA, S_DRAIN} state_t;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? CRC5_POLY : 5'h00);
    return r;
  endfunction
endpackage

// File: rtl/usb_rx_pkt_crc16.sv
// usb_crc16: LSB-first CRC16 over bytes; residual_ok reflects the value after this clk's update
//  clk, reset_n : clock, async active-low reset
//  init, en     : load CRC16_INIT / fold data into the CRC
//  data         : byte to fold
//  residual_ok  : next CRC state equals CRC16_RESIDUAL
module usb_crc16 import usb_rx_pkt_pkg::*; (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] data,
  output logic       residual_ok
);
  logic [15:0] crc_q, crc_d;
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? CRC16_POLY : 16'h0000);
    return r;
  endfunction
  always_comb crc_d = init ? CRC16_INIT : en ? crc16_byte(crc_q, data) : crc_q;
  // Looking at the next value lets a byte and end-of-packet share a clock
  assign residual_ok = crc_d == CRC16_RESIDUAL;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) crc_q <= CRC16_INIT;
    else crc_q <= crc_d;
endmodule

// File: rtl/usb_rx_pkt.sv
// usb_rx_pkt: USB packet decoder behind usb_rx (PID/CRC5/CRC16/length checks, token/handshake/payload out)
//  in : clk, reset_n (async active-low), rx_data[7:0], rx_active, rx_valid, rx_error
//  out: pid[3:0], token_valid/addr[6:0]/endp[3:0], hsk_valid, dat_valid/dat_out[7:0],
//       dat_done/dat_ok, sof_valid/frame_num[10:0], pkt_err
//  USB_RX_PKT_SOF_EN: decode SOF into sof_valid/frame_num; otherwise SOF is checked and dropped
module usb_rx_pkt import usb_rx_pkt_pkg::*; #(
  parameter int MAX_PKT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic        token_valid,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic        hsk_valid,
  output logic        dat_valid,
  output logic [7:0]  dat_out,
  output logic        dat_done,
  output logic        dat_ok,
  output logic        sof_valid,
  output logic [10:0] frame_num,
  output logic        pkt_err
);
  localparam int PW = $clog2(MAX_PKT + 2);
  localparam logic [PW-1:0] MAXP = PW'(MAX_PKT);
  state_t state_q, state_d;
  logic active_q, eop, crc_init, crc_en, crc_ok, ok;
  logic [3:0] pid_q, pid_d;
  logic [7:0] b1_q, b1_d, dl0_q, dl0_d, dl1_q, dl1_d, dat_out_q, dat_out_d;
  logic [2:0] b2_q, b2_d;
  logic [4:0] crc5_q, crc5_d;
  logic [1:0] fill_q, fill_d;
  logic [PW-1:0] pay_q, pay_d;
  logic pend_q, pend_d;
  logic token_valid_q, token_valid_d, hsk_valid_q, hsk_valid_d, dat_valid_q, dat_valid_d;
  logic dat_done_q, dat_done_d, dat_ok_q, dat_ok_d, pkt_err_q, pkt_err_d;
  logic [6:0] token_addr_q, token_addr_d;
  logic [3:0] token_endp_q, token_endp_d;
`ifdef USB_RX_PKT_SOF_EN
  logic sof_valid_q, sof_valid_d;
  logic [10:0] frame_num_q, frame_num_d;
`endif
  assign eop = active_q & ~rx_active;
  usb_crc16 u_crc16 (
    .clk         (clk),
    .reset_n     (reset_n),
    .init        (crc_init),
    .en          (crc_en),
    .data        (rx_data),
    .residual_ok (crc_ok)
  );
  // Byte (or rx_error) is applied first; end-of-packet then acts on the updated state
  always_comb begin
    state_d = (state_q == S_IDLE && rx_active) ? S_PID : state_q;
    pid_d = pid_q;
    b1_d = b1_q;
    b2_d = b2_q;
    crc5_d = crc5_q;
    dl0_d = dl0_q;
    dl1_d = dl1_q;
    fill_d = fill_q;
    pay_d = pay_q;
    pend_d = pend_q;
    dat_out_d = dat_out_q;
    token_addr_d = token_addr_q;
    token_endp_d = token_endp_q;
    token_valid_d = 1'b0;
    hsk_valid_d = 1'b0;
    dat_valid_d = 1'b0;
    dat_done_d = 1'b0;
    dat_ok_d = 1'b0;
    pkt_err_d = 1'b0;
    crc_init = 1'b0;
    crc_en = 1'b0;
    ok = 1'b0;
`ifdef USB_RX_PKT_SOF_EN
    sof_valid_d = 1'b0;
    frame_num_d = frame_num_q;
`endif
    if (state_d != S_IDLE && rx_error) begin
      pkt_err_d = 1'b1;
      pend_d = pend_q | (state_d == S_DATA);
      state_d = S_DRAIN;
    end else if (rx_valid) begin
      case (state_d)
        S_PID: begin
          pid_d = rx_data[3:0];
          crc5_d = CRC5_INIT;
          crc_init = 1'b1;
          fill_d = 2'd0;
          pay_d = '0;
          pend_d = 1'b0;
          if (rx_data[7:4] != ~rx_data[3:0]) begin
            pkt_err_d = 1'b1;
            state_d = S_DRAIN;
          end else begin
            case (rx_data[3:0])
              PID_OUT, PID_IN, PID_SETUP, PID_SOF: state_d = S_TOK1;
              PID_DATA0, PID_DATA1: state_d = S_DATA;
              PID_ACK, PID_NAK, PID_STALL: state_d = S_HSK;
              default: state_d = S_DRAIN;
            endcase
          end
        end
        S_TOK1: begin
          b1_d = rx_data;
          crc5_d = crc5_byte(crc5_q, rx_data);
          state_d = S_TOK2;
        end
        S_TOK2: begin
          b2_d = rx_data[2:0];
          crc5_d = crc5_byte(crc5_q, rx_data);
          state_d = S_TEND;
        end
        S_TEND, S_HSK: begin
          pkt_err_d = 1'b1;
          state_d = S_DRAIN;
        end
        S_DATA: begin
          crc_en = 1'b1;
          dl1_d = dl0_q;
          dl0_d = rx_data;
          fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
          // The two newest bytes may be CRC16, so only a byte pushed out by a third is payload
          if (fill_q == 2'd2) begin
            pay_d = (pay_q <= MAXP) ? pay_q + PW'(1) : pay_q;
            if (pay_q < MAXP) begin
              dat_valid_d = 1'b1;
              dat_out_d = dl1_q;
            end
          end
        end
        default: ;
      endcase
    end
    if (eop) begin
      case (state_d)
        S_TEND:
          if (crc5_d != CRC5_RESIDUAL) pkt_err_d = 1'b1;
          else if (pid_d == PID_SOF) begin
`ifdef USB_RX_PKT_SOF_EN
            sof_valid_d = 1'b1;
            frame_num_d = {b2_d, b1_d};
`endif
          end else begin
            token_valid_d = 1'b1;
            token_addr_d = b1_d[6:0];
            token_endp_d = {b2_d, b1_d[7]};
          end
        S_PID, S_TOK1, S_TOK2: pkt_err_d = 1'b1;
        S_HSK: hsk_valid_d = 1'b1;
        S_DATA: begin
          ok = crc_ok & (fill_d == 2'd2) & (pay_d <= MAXP);
          dat_done_d = 1'b1;
          dat_ok_d = ok;
          pkt_err_d = ~ok;
        end
        S_DRAIN: dat_done_d = pend_d;
        default: ;
      endcase
      pend_d = 1'b0;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      active_q <= 1'b0;
      pid_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      crc5_q <= '0;
      dl0_q <= '0;
      dl1_q <= '0;
      fill_q <= '0;
      pay_q <= '0;
      pend_q <= 1'b0;
      dat_out_q <= '0;
      token_addr_q <= '0;
      token_endp_q <= '0;
      token_valid_q <= 1'b0;
      hsk_valid_q <= 1'b0;
      dat_valid_q <= 1'b0;
      dat_done_q <= 1'b0;
      dat_ok_q <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      active_q <= rx_active;
      pid_q <= pid_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      crc5_q <= crc5_d;
      dl0_q <= dl0_d;
      dl1_q <= dl1_d;
      fill_q <= fill_d;
      pay_q <= pay_d;
      pend_q <= pend_d;
      dat_out_q <= dat_out_d;
      token_addr_q <= token_addr_d;
      token_endp_q <= token_endp_d;
      token_valid_q <= token_valid_d;
      hsk_valid_q <= hsk_valid_d;
      dat_valid_q <= dat_valid_d;
      dat_done_q <= dat_done_d;
      dat_ok_q <= dat_ok_d;
      pkt_err_q <= pkt_err_d;
    end
`ifdef USB_RX_PKT_SOF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sof_valid_q <= 1'b0;
      frame_num_q <= '0;
    end else begin
      sof_valid_q <= sof_valid_d;
      frame_num_q <= frame_num_d;
    end
  assign sof_valid = sof_valid_q;
  assign frame_num = frame_num_q;
`else
  assign sof_valid = 1'b0;
  assign frame_num = '0;
`endif
  assign pid = pid_q;
  assign token_valid = token_valid_q;
  assign token_addr = token_addr_q;
  assign token_endp = token_endp_q;
  assign hsk_valid = hsk_valid_q;
  assign dat_valid = dat_valid_q;
  assign dat_out = dat_out_q;
  assign dat_done = dat_done_q;
  assign dat_ok = dat_ok_q;
  assign pkt_err = pkt_err_q;
endmodule

// File: tb/tb_usb_rx_pkt.sv
// tb_usb_rx_pkt: scoreboard bench for usb_rx_pkt (expected result events queued by stimulus, popped by monitor)
module tb_usb_rx_pkt;
  logic clk = 1'b0;
  logic reset_n, rx_active, rx_valid, rx_error;
  logic [7:0] rx_data;
  logic [3:0] pid, token_endp;
  logic [6:0] token_addr;
  logic [7:0] dat_out;
  logic [10:0] frame_num;
  logic token_valid, hsk_valid, dat_valid, dat_done, dat_ok, sof_valid, pkt_err, res;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pkt [0:79];
  localparam logic [6:0] F_TOK = 7'b1000000, F_HSK = 7'b0100000, F_DV = 7'b0010000,
                         F_DONE = 7'b0001000, F_OK = 7'b0000100, F_SOF = 7'b0000010, F_ERR = 7'b0000001;
  typedef struct packed {
    logic [6:0]  f;
    logic [3:0]  p;
    logic [6:0]  a;
    logic [3:0]  e;
    logic [10:0] d;
  } ev_t;
  ev_t expq[$];
  always #5 clk = ~clk;
  usb_rx_pkt #(.MAX_PKT(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_active   (rx_active),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .pid         (pid),
    .token_valid (token_valid),
    .token_addr  (token_addr),
    .token_endp  (token_endp),
    .hsk_valid   (hsk_valid),
    .dat_valid   (dat_valid),
    .dat_out     (dat_out),
    .dat_done    (dat_done),
    .dat_ok      (dat_ok),
    .sof_valid   (sof_valid),
    .frame_num   (frame_num),
    .pkt_err     (pkt_err)
  );
  assign res = token_valid | hsk_valid | sof_valid | dat_done | pkt_err;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input logic [6:0] f, input logic [3:0] p, input logic [6:0] a = '0,
                      input logic [3:0] e = '0, input logic [10:0] d = '0);
    ev_t x;
    x.f = f;
    x.p = p;
    x.a = a;
    x.e = e;
    x.d = d;
    expq.push_back(x);
  endtask
  task automatic mk_tok(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    logic [10:0] v;
    logic [4:0] c;
    v = {e, a};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((v[i] ^ c[4]) ? 5'h05 : 5'h00);
    pkt[0] = {~p, p};
    pkt[1] = v[7:0];
    pkt[2] = {~c[0], ~c[1], ~c[2], ~c[3], ~c[4], v[10:8]};
  endtask
  task automatic add_crc16(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 1; i <= n; i++)
      for (int b = 0; b < 8; b++) c = {c[14:0], 1'b0} ^ ((pkt[i][b] ^ c[15]) ? 16'h8005 : 16'h0000);
    for (int b = 0; b < 8; b++) begin
      pkt[n+1][b] = ~c[15-b];
      pkt[n+2][b] = ~c[7-b];
    end
  endtask
  task automatic send(input int len, input bit same_end = 1'b0, input int err_at = -1, input bit lat = 1'b0);
    rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_data = pkt[i];
      if (same_end && i == len - 1) rx_active = 1'b0;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (i == err_at) begin
        rx_error = 1'b1;
        @(posedge clk); #1;
        rx_error = 1'b0;
      end
      @(posedge clk); #1;
    end
    rx_active = 1'b0;
    if (lat) begin
      chk("lat_early", 64'(res), 64'(1'b0));
      @(posedge clk); #1;
      chk("lat_pulse", 64'(res), 64'(1'b1));
      @(posedge clk); #1;
      chk("lat_width", 64'(res), 64'(1'b0));
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : mon
    ev_t e;
    logic [6:0] f;
    f = {token_valid, hsk_valid, dat_valid, dat_done, dat_ok, sof_valid, pkt_err};
    if (reset_n && f != 7'd0) begin
      if (expq.size() == 0) chk("unexpected_event", 64'(f), 64'(0));
      else begin
        e = expq.pop_front();
        chk("flags", 64'(f), 64'(e.f));
        chk("pid", 64'(pid), 64'(e.p));
        if (token_valid) begin
          chk("token_addr", 64'(token_addr), 64'(e.a));
          chk("token_endp", 64'(token_endp), 64'(e.e));
        end
        if (dat_valid) chk("dat_out", 64'(dat_out), 64'(e.d));
        if (sof_valid) chk("frame_num", 64'(frame_num), 64'(e.d));
      end
    end
  end
  initial begin
    reset_n = 1'b0;
    rx_active = 1'b0;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 64'({pid, token_valid, token_addr, token_endp, hsk_valid, dat_valid, dat_out,
                           dat_done, dat_ok, sof_valid, frame_num, pkt_err}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    // SETUP addr 0 endp 0, hand vector
    pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10;
    push(F_TOK, 4'hD, 7'h00, 4'h0);
    send(3, 1'b0, -1, 1'b1);
    // OUT addr 3A endp 5, last byte coincides with end-of-packet
    mk_tok(4'h1, 7'h3A, 4'h5);
    push(F_TOK, 4'h1, 7'h3A, 4'h5);
    send(3, 1'b1);
    // ACK, then corrupted PID
    pkt[0] = 8'hD2;
    push(F_HSK, 4'h2);
    send(1, 1'b0, -1, 1'b1);
    pkt[0] = 8'h2C; pkt[1] = 8'h00; pkt[2] = 8'h10;
    push(F_ERR, 4'hC);
    send(3);
    // ZLP
    pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt[2] = 8'h00;
    push(F_DONE | F_OK, 4'h3);
    send(3);
    // DATA1 with 00..07
    pkt[0] = 8'h4B;
    for (int i = 0; i < 8; i++) pkt[i+1] = 8'(i);
    add_crc16(8);
    for (int i = 0; i < 8; i++) push(F_DV, 4'hB, '0, '0, 11'(i));
    push(F_DONE | F_OK, 4'hB);
    send(11);
    // DATA0 with one payload bit flipped after the CRC was computed
    pkt[0] = 8'hC3;
    for (int i = 0; i < 8; i++) pkt[i+1] = 8'hA0 + 8'(i);
    add_crc16(8);
    pkt[3] = pkt[3] ^ 8'h04;
    for (int i = 1; i <= 8; i++) push(F_DV, 4'h3, '0, '0, 11'(pkt[i]));
    push(F_DONE | F_ERR, 4'h3);
    send(11);
    // DATA0 with MAX_PKT+1 payload bytes and a correct CRC
    pkt[0] = 8'hC3;
    for (int i = 1; i <= 65; i++) pkt[i] = 8'(i * 3) ^ 8'h55;
    add_crc16(65);
    for (int i = 1; i <= 64; i++) push(F_DV, 4'h3, '0, '0, 11'(pkt[i]));
    push(F_DONE | F_ERR, 4'h3);
    send(68);
    // rx_error after token byte1, then a normal ACK
    mk_tok(4'h9, 7'h12, 4'h3);
    push(F_ERR, 4'h9);
    send(3, 1'b0, 1);
    pkt[0] = 8'hD2;
    push(F_HSK, 4'h2);
    send(1);
    // SOF frame 7FF
    mk_tok(4'h5, 7'h7F, 4'hF);
`ifdef USB_RX_PKT_SOF_EN
    push(F_SOF, 4'h5, '0, '0, 11'h7FF);
`endif
    send(3);
    chk("sof_pid", 64'(pid), 64'(4'h5));
    // reset in the middle of a DATA0 packet while dat_valid is high
    pkt[0] = 8'hC3; pkt[1] = 8'h5A; pkt[2] = 8'h11; pkt[3] = 8'h22;
    push(F_DV, 4'h3, '0, '0, 11'h05A);
    rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data = pkt[i];
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("pre_rst_dat_valid", 64'(dat_valid), 64'(1'b1));
    chk("pre_rst_pid", 64'(pid), 64'(4'h3));
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_pid", 64'(pid), 64'(0));
    chk("rst_dat_out", 64'(dat_out), 64'(0));
    chk("rst_all_outs", 64'({pid, token_valid, token_addr, token_endp, hsk_valid, dat_valid, dat_out,
                             dat_done, dat_ok, sof_valid, frame_num, pkt_err}), 64'(0));
    rx_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    pkt[0] = 8'hD2;
    push(F_HSK, 4'h2);
    send(1);
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(expq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
